// File: rtl/aes128_host_pkg.sv
// Register map, control/status bit positions and FSM states for the AES-128 host interface.
package aes128_host_pkg;

  localparam logic [5:0] KEY_BASE  = 6'h00;
  localparam logic [5:0] DATA_BASE = 6'h10;
  localparam logic [5:0] RES_BASE  = 6'h20;
  localparam logic [5:0] CTRL      = 6'h30;
  localparam logic [5:0] STATUS    = 6'h34;
  localparam logic [5:0] CLEAR     = 6'h38;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_DEC_BIT    = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  // CLEAR reuses the STATUS bit positions for done and error.
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_BUSY    = 2'd2,
    ST_CAPTURE = 2'd3
  } host_state_e;

  // Word 0 is the most significant 32 bits of the 128-bit value.
  function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] idx);
    logic [6:0] lsb;
    lsb = 7'd96 - {idx, 5'd0};
    return v[lsb +: 32];
  endfunction

endpackage

// File: rtl/aes128_type_pkg.sv
// Shared AES-128 type definitions used by the core and its front ends.
package aes128_type_pkg;

  typedef enum logic [1:0] {
    AES_MODE_ENC = 2'd0,
    AES_MODE_DEC = 2'd1
  } aes_mode_e;

endpackage

// File: rtl/aes128_word_bank.sv
// Four 32-bit words packed big-endian into 128 bits; writes are ignored while locked.
module aes128_word_bank (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         wr_en_i,
  input  logic [1:0]   idx_i,
  input  logic [31:0]  wdata_i,
  input  logic         lock_i,
  output logic [127:0] data_o
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_word
    logic [31:0] r_word;

    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        r_word <= '0;
      end else if (wr_en_i && !lock_i && (idx_i == 2'(gi))) begin
        r_word <= wdata_i;
      end
    end

    assign data_o[127 - 32*gi -: 32] = r_word;
  end

endmodule

// File: rtl/aes128_host_if.sv
// Bus-facing register front end for the AES-128 core: key/data assembly,
// start handshake, busy tracking, result capture and interrupt.
module aes128_host_if
  import aes128_type_pkg::*;
  import aes128_host_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [5:0]   addr_i,
  input  logic [31:0]  wdata_i,
  input  logic         wr_en_i,
  input  logic         rd_en_i,
  output logic [31:0]  rdata_o,
  output logic         rd_valid_o,
  output logic         irq_o,
  output logic         core_start_o,
  output logic [1:0]   core_op_o,
  output logic [127:0] core_key_o,
  output logic [127:0] core_data_o,
  input  logic [127:0] core_result_i,
  input  logic         core_valid_i,
  input  logic         core_ready_i
);

  host_state_e  r_state, w_state_next;
  aes_mode_e    r_op, w_op_next;
  logic         r_irq_en, w_irq_en_next;
  logic         r_done, w_done_next;
  logic         r_err, w_err_next;
  logic [127:0] r_result;
  logic [31:0]  r_rdata;
  logic         r_rd_valid;

  logic [31:0]  w_rd_value;
  logic [1:0]   w_op_bits;
  logic [1:0]   w_idx;
  logic         w_busy;
  logic         w_hit_key, w_hit_data, w_hit_res;
  logic         w_hit_ctrl, w_hit_status, w_hit_clear;
  logic         w_key_we, w_data_we, w_wr_ctrl, w_wr_clear;
  logic         w_start_req, w_launch, w_new_err;

  assign w_idx        = addr_i[3:2];
  assign w_hit_key    = (addr_i[5:4] == KEY_BASE[5:4]);
  assign w_hit_data   = (addr_i[5:4] == DATA_BASE[5:4]);
  assign w_hit_res    = (addr_i[5:4] == RES_BASE[5:4]);
  assign w_hit_ctrl   = (addr_i[5:2] == CTRL[5:2]);
  assign w_hit_status = (addr_i[5:2] == STATUS[5:2]);
  assign w_hit_clear  = (addr_i[5:2] == CLEAR[5:2]);

  assign w_busy      = (r_state != ST_IDLE);
  assign w_key_we    = wr_en_i && w_hit_key;
  assign w_data_we   = wr_en_i && w_hit_data;
  assign w_wr_ctrl   = wr_en_i && w_hit_ctrl;
  assign w_wr_clear  = wr_en_i && w_hit_clear;
  assign w_start_req = w_wr_ctrl && wdata_i[CTRL_START_BIT];
  assign w_launch    = w_start_req && (r_state == ST_IDLE) && core_ready_i;
  // A refused start (busy or core not ready) and a dropped key/data write both flag error.
  assign w_new_err   = (w_start_req && !w_launch) || ((w_key_we || w_data_we) && w_busy);

  // Key and data are frozen while an operation is in flight.
  aes128_word_bank u_key_bank (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .wr_en_i (w_key_we),
    .idx_i   (w_idx),
    .wdata_i (wdata_i),
    .lock_i  (w_busy),
    .data_o  (core_key_o)
  );

  aes128_word_bank u_data_bank (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .wr_en_i (w_data_we),
    .idx_i   (w_idx),
    .wdata_i (wdata_i),
    .lock_i  (w_busy),
    .data_o  (core_data_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    core_start_o = 1'b0;
    unique case (r_state)
      ST_IDLE:    if (w_launch) w_state_next = ST_LAUNCH;
      ST_LAUNCH: begin
        core_start_o = 1'b1;
        w_state_next = ST_BUSY;
      end
      ST_BUSY:    if (core_valid_i) w_state_next = ST_CAPTURE;
      ST_CAPTURE: w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_op_next     = r_op;
    w_irq_en_next = r_irq_en;
    w_done_next   = r_done;
    w_err_next    = r_err;
    if (w_launch) begin
      w_op_next = wdata_i[CTRL_DEC_BIT] ? AES_MODE_DEC : AES_MODE_ENC;
    end
    if (w_wr_ctrl) begin
      w_irq_en_next = wdata_i[CTRL_IRQ_EN_BIT];
    end
    // Later assignments take priority: capture beats clear, new error beats clear.
    if (w_wr_clear && wdata_i[STAT_DONE_BIT]) w_done_next = 1'b0;
    if (w_launch)                             w_done_next = 1'b0;
    if (r_state == ST_CAPTURE)                w_done_next = 1'b1;
    if (w_wr_clear && wdata_i[STAT_ERR_BIT])  w_err_next  = 1'b0;
    if (w_new_err)                            w_err_next  = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_op     <= AES_MODE_ENC;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      r_op     <= w_op_next;
      r_irq_en <= w_irq_en_next;
      r_done   <= w_done_next;
      r_err    <= w_err_next;
      if (r_state == ST_CAPTURE) begin
        r_result <= core_result_i;
      end
    end
  end

  assign w_op_bits = w_op_next;

  // Bus-written registers forward a same-cycle write; RESULT shows the pre-capture value.
  always_comb begin
    w_rd_value = '0;
    if (w_hit_key) begin
      w_rd_value = (w_key_we && !w_busy) ? wdata_i : word_of(core_key_o, w_idx);
    end else if (w_hit_data) begin
      w_rd_value = (w_data_we && !w_busy) ? wdata_i : word_of(core_data_o, w_idx);
    end else if (w_hit_res) begin
      w_rd_value = word_of(r_result, w_idx);
    end else if (w_hit_ctrl) begin
      w_rd_value[CTRL_IRQ_EN_BIT] = w_irq_en_next;
      w_rd_value[CTRL_DEC_BIT]    = w_op_bits[0];
    end else if (w_hit_status) begin
      w_rd_value[STAT_BUSY_BIT] = w_busy;
      w_rd_value[STAT_DONE_BIT] = r_done;
      w_rd_value[STAT_ERR_BIT]  = r_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_rdata    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rdata    <= rd_en_i ? w_rd_value : 32'd0;
      r_rd_valid <= rd_en_i;
    end
  end

  assign rdata_o    = r_rdata;
  assign rd_valid_o = r_rd_valid;
  assign irq_o      = r_done & r_irq_en;
  assign core_op_o  = r_op;

endmodule

// File: tb/tb_aes128_host_if.sv
// Directed bench for aes128_host_if with a behavioural AES core stand-in that returns FIPS-197 vectors.
module tb_aes128_host_if;

  localparam logic [127:0] K_VEC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_VEC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_VEC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam int LAT = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [5:0]   addr = '0;
  logic [31:0]  wdata = '0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [31:0]  rdata;
  logic         rd_valid;
  logic         irq;
  logic         core_start;
  logic [1:0]   core_op;
  logic [127:0] core_key;
  logic [127:0] core_data;
  logic [127:0] m_result;
  logic [127:0] m_pending;
  logic         m_valid;
  logic         m_ready;
  logic         hold_nr = 1'b0;
  int           m_cnt;
  int           start_cnt = 0;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  aes128_host_if dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .wr_en_i       (wr_en),
    .rd_en_i       (rd_en),
    .rdata_o       (rdata),
    .rd_valid_o    (rd_valid),
    .irq_o         (irq),
    .core_start_o  (core_start),
    .core_op_o     (core_op),
    .core_key_o    (core_key),
    .core_data_o   (core_data),
    .core_result_i (m_result),
    .core_valid_i  (m_valid),
    .core_ready_i  (m_ready && !hold_nr)
  );

  function automatic logic [127:0] lookup(input logic [1:0] op, input logic [127:0] k,
                                          input logic [127:0] d);
    if (op == 2'd0 && k == K_VEC && d == P_VEC) return C_VEC;
    if (op == 2'd1 && k == K_VEC && d == C_VEC) return P_VEC;
    return 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
  endfunction

  // Core stand-in: clears valid on the edge that samples start, answers LAT cycles later.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_ready <= 1'b1; m_cnt <= 0; m_result <= '0; m_pending <= '0;
    end else if (core_start) begin
      m_valid <= 1'b0; m_ready <= 1'b0; m_cnt <= LAT;
      m_pending <= lookup(core_op, core_key, core_data);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_valid <= 1'b1; m_ready <= 1'b1; m_result <= m_pending;
      end
    end
  end

  always @(posedge clk) if (core_start) start_cnt <= start_cnt + 1;

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk); addr = a; wdata = d; wr_en = 1'b1;
    @(negedge clk); wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk); addr = a; rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0; d = rdata;
  endtask

  task automatic load_vec(input logic [5:0] base, input logic [127:0] v);
    for (int i = 0; i < 4; i++) bus_write(base + 6'(4*i), v[127-32*i -: 32]);
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    for (int i = 0; i < 60; i++) begin
      bus_read(6'h34, s);
      if (!s[0]) return;
    end
    checks++; errors++;
    $display("FAIL wait_idle: busy still %0d after 60 polls, required 0", s[0]);
  endtask

  task automatic wait_valid();
    @(negedge clk);  // BUSY: stale valid already cleared
    for (int i = 0; i < 60; i++) begin
      if (m_valid) return;
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL wait_valid: core_valid_i never rose, required 1");
  endtask

  task automatic check_result(input string name, input logic [127:0] exp);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      bus_read(6'h20 + 6'(4*i), v);
      checks++;
      if (v !== exp[127-32*i -: 32]) begin
        errors++;
        $display("FAIL %s RESULT%0d: got %h, required %h", name, i, v, exp[127-32*i -: 32]);
      end
    end
    $display("%s result checked", name);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({irq, core_start, rd_valid, core_op} !== 5'b0 || rdata !== 32'd0 ||
        core_key !== '0 || core_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: irq=%b start=%b rdv=%b op=%0d rdata=%h, required all 0",
               irq, core_start, rd_valid, core_op, rdata);
    end
    bus_read(6'h34, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL reset_status: got %h, required 0", v); end
    $display("test_reset done");
  endtask

  task automatic test_encrypt();
    logic [31:0] v;
    int s0;
    load_vec(6'h00, K_VEC);
    load_vec(6'h10, P_VEC);
    s0 = start_cnt;
    @(negedge clk); addr = 6'h30; wdata = 32'h1; wr_en = 1'b1;
    checks++;
    if (core_start !== 1'b0) begin errors++; $display("FAIL start_N: got %b, required 0", core_start); end
    @(negedge clk); wr_en = 1'b0;
    checks++;
    if (core_start !== 1'b1) begin errors++; $display("FAIL start_N1: got %b, required 1", core_start); end
    @(negedge clk);
    checks++;
    if (core_start !== 1'b0) begin errors++; $display("FAIL start_N2: got %b, required 0", core_start); end
    wait_idle();
    checks++;
    if (start_cnt - s0 !== 1) begin errors++; $display("FAIL enc_pulses: got %0d, required 1", start_cnt - s0); end
    bus_read(6'h34, v);
    checks++;
    if (v !== 32'h2) begin errors++; $display("FAIL enc_status: got %h, required 00000002", v); end
    check_result("encrypt", C_VEC);
  endtask

  task automatic test_decrypt();
    logic [31:0] v;
    load_vec(6'h10, C_VEC);
    bus_write(6'h30, 32'h3);
    checks++;
    if (core_op !== 2'd1) begin errors++; $display("FAIL dec_op: got %0d, required 1", core_op); end
    wait_idle();
    bus_read(6'h30, v);
    checks++;
    if (v !== 32'h2) begin errors++; $display("FAIL dec_ctrl_rd: got %h, required 00000002", v); end
    check_result("decrypt", P_VEC);
  endtask

  task automatic test_busy_writes();
    logic [31:0] v;
    int s0;
    load_vec(6'h10, P_VEC);
    s0 = start_cnt;
    bus_write(6'h30, 32'h1);
    bus_write(6'h30, 32'h1);
    bus_write(6'h00, 32'hffffffff);
    bus_read(6'h34, v);
    checks++;
    if (v !== 32'h5) begin errors++; $display("FAIL busy_status: got %h, required 00000005", v); end
    bus_read(6'h00, v);
    checks++;
    if (v !== 32'h00010203) begin errors++; $display("FAIL busy_key0: got %h, required 00010203", v); end
    wait_idle();
    checks++;
    if (start_cnt - s0 !== 1) begin errors++; $display("FAIL busy_pulses: got %0d, required 1", start_cnt - s0); end
    check_result("busy_enc", C_VEC);
    bus_write(6'h38, 32'h4);
    bus_read(6'h34, v);
    checks++;
    if (v !== 32'h2) begin errors++; $display("FAIL clear_err: got %h, required 00000002", v); end
    bus_write(6'h38, 32'h6);
    hold_nr = 1'b1;
    s0 = start_cnt;
    bus_write(6'h30, 32'h1);
    repeat (2) @(negedge clk);
    bus_read(6'h34, v);
    checks++;
    if (v !== 32'h4 || start_cnt != s0) begin
      errors++;
      $display("FAIL not_ready: status %h pulses %0d, required 00000004 and 0", v, start_cnt - s0);
    end
    hold_nr = 1'b0;
    bus_write(6'h38, 32'h4);
    $display("test_busy_writes done");
  endtask

  task automatic test_irq();
    logic [31:0] v;
    bus_write(6'h30, 32'h5);
    wait_valid();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_M: got %b, required 0", irq); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_M1: got %b, required 0", irq); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_M2: got %b, required 1", irq); end
    bus_write(6'h38, 32'h2);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b, required 0", irq); end
    bus_write(6'h30, 32'h1);
    wait_idle();
    bus_read(6'h34, v);
    checks++;
    if (irq !== 1'b0 || v !== 32'h2) begin
      errors++;
      $display("FAIL irq_disabled: irq %b status %h, required 0 and 00000002", irq, v);
    end
    $display("test_irq done");
  endtask

  task automatic test_clear_capture();
    logic [31:0] v;
    bus_write(6'h30, 32'h1);
    wait_valid();
    @(negedge clk); addr = 6'h38; wdata = 32'h2; wr_en = 1'b1;
    @(negedge clk); wr_en = 1'b0;
    bus_read(6'h34, v);
    checks++;
    if (v !== 32'h2) begin errors++; $display("FAIL clear_vs_capture: got %h, required 00000002", v); end
    $display("test_clear_capture done");
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    bus_write(6'h30, 32'h5);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL rst_mid_irq: got %b, required 0", irq); end
    bus_read(6'h34, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL rst_mid_status: got %h, required 0", v); end
    check_result("rst_mid_zero", 128'h0);
    load_vec(6'h00, K_VEC);
    load_vec(6'h10, P_VEC);
    bus_write(6'h30, 32'h1);
    wait_idle();
    check_result("rst_mid_reenc", C_VEC);
  endtask

  task automatic test_bus_edges();
    logic [31:0] v;
    @(negedge clk); addr = 6'h3c; rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rdata !== 32'd0) begin
      errors++; $display("FAIL rd_unmapped: valid %b data %h, required 1 and 0", rd_valid, rdata);
    end
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_drop: got %b, required 0", rd_valid); end
    bus_write(6'h3c, 32'hffffffff);
    bus_read(6'h3c, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL wr_unmapped: got %h, required 0", v); end
    bus_read(6'h34, v);
    checks++;
    if (v !== 32'h2) begin errors++; $display("FAIL wr_unmapped_status: got %h, required 00000002", v); end
    @(negedge clk); addr = 6'h0c; wdata = 32'ha5a5a5a5; wr_en = 1'b1; rd_en = 1'b1;
    @(negedge clk); wr_en = 1'b0; rd_en = 1'b0;
    checks++;
    if (rdata !== 32'ha5a5a5a5) begin errors++; $display("FAIL rd_same_cycle: got %h, required a5a5a5a5", rdata); end
    bus_write(6'h0c, 32'h0c0d0e0f);
    load_vec(6'h10, C_VEC);
    bus_write(6'h30, 32'h3);
    wait_valid();
    @(negedge clk); addr = 6'h20; rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    checks++;
    if (rdata !== 32'h69c4e0d8) begin errors++; $display("FAIL rd_capture_old: got %h, required 69c4e0d8", rdata); end
    bus_read(6'h20, v);
    checks++;
    if (v !== 32'h00112233) begin errors++; $display("FAIL rd_capture_new: got %h, required 00112233", v); end
    $display("test_bus_edges done");
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_busy_writes();
    test_irq();
    test_clear_capture();
    test_reset_mid();
    test_bus_edges();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
